// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: round-robin sharing of the single-port data memory between two requesters
module dm_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_byte,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_byte,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_we,
  output logic              dm_op,
  input  logic [DATA_W-1:0] dm_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic last_grant, win, we_l, byte_l, err_l;
  logic any_req, pick, sel_we, sel_byte;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  // last_grant = 1 means M1 was served last, so M0 wins the next tie
  assign any_req   = m0_req | m1_req;
  assign pick      = m1_req & (~m0_req | ~last_grant);
  assign sel_we    = pick ? m1_we : m0_we;
  assign sel_byte  = pick ? m1_byte : m0_byte;
  assign sel_addr  = pick ? m1_addr : m0_addr;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and decoded outputs; memory strobes only in ACCESS
  always_comb begin
    state_n = state == IDLE ? (any_req ? ACCESS : IDLE) : (state == ACCESS ? DONE : IDLE);
    m0_ack  = (state == DONE) & ~win;
    m1_ack  = (state == DONE) & win;
    m0_err  = m0_ack & err_l;
    m1_err  = m1_ack & err_l;
    dm_we   = (state == ACCESS) & we_l & ~err_l;
    dm_op   = (state == ACCESS) & we_l & byte_l;
  end
  // latch the winner's attributes on the grant edge and capture load data at the end of ACCESS
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_grant <= 1'b1;
      win        <= 1'b0;
      we_l       <= 1'b0;
      byte_l     <= 1'b0;
      err_l      <= 1'b0;
      dm_addr    <= '0;
      dm_din     <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        win        <= pick;
        last_grant <= pick;
        we_l       <= sel_we;
        byte_l     <= sel_byte;
        dm_addr    <= sel_addr;
        dm_din     <= sel_wdata;
        err_l      <= (sel_addr[1:0] != 2'b00) & ~(sel_we & sel_byte);
      end
      if (state == ACCESS && (err_l || !we_l)) begin
        if (win) m1_rdata <= err_l ? '0 : dm_dout;
        else m0_rdata <= err_l ? '0 : dm_dout;
      end
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed transactions checked against a transaction-level model every cycle
module tb_dm_port_arbiter;
  logic clk = 0, rst = 1;
  logic m0_req = 0, m0_we = 0, m0_byte = 0, m1_req = 0, m1_we = 0, m1_byte = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_ack, m0_err, m1_ack, m1_err, dm_we, dm_op;
  logic [31:0] m0_rdata, m1_rdata, dm_addr, dm_din, dm_dout;
  logic [31:0] mem [1024];
  logic [31:0] mm [1024];
  int tests = 0, fails = 0;
  bit run = 0;
  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_byte(m0_byte), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_byte(m1_byte), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_op(dm_op), .dm_dout(dm_dout)
  );

  // memory attached to the DUT: combinational read, byte or word write on the clock edge
  assign dm_dout = mem[dm_addr[11:2]];
  always @(posedge clk)
    if (dm_we) begin
      if (dm_op) mem[dm_addr[11:2]][8*dm_addr[1:0] +: 8] <= dm_din[7:0];
      else mem[dm_addr[11:2]] <= dm_din;
    end

  initial for (int i = 0; i < 1024; i++) begin mem[i] = 0; mm[i] = 0; end

  // transaction model: ph 0 = free, 1 = memory access cycle, 2 = completion cycle
  int ph;
  bit mw, mwe, mbt, merr, mlast;
  logic [31:0] ma, md;
  logic [31:0] mrd [2];
  logic bw;
  assign bw = (m0_req && m1_req) ? !mlast : m1_req;
  always @(posedge clk or posedge rst)
    if (rst) begin
      ph <= 0; mlast <= 1; mw <= 0; mwe <= 0; mbt <= 0; merr <= 0; ma <= 0; md <= 0;
      mrd[0] <= 0; mrd[1] <= 0;
    end else if (ph == 1) begin
      if (merr) mrd[mw] <= 0;
      else if (!mwe) mrd[mw] <= mm[ma[11:2]];
      else if (mbt) mm[ma[11:2]][8*ma[1:0] +: 8] <= md[7:0];
      else mm[ma[11:2]] <= md;
      ph <= 2;
    end else if (ph == 2) ph <= 0;
    else if (m0_req || m1_req) begin
      mw <= bw; mlast <= bw;
      mwe <= bw ? m1_we : m0_we;
      mbt <= bw ? m1_byte : m0_byte;
      ma <= bw ? m1_addr : m0_addr;
      md <= bw ? m1_wdata : m0_wdata;
      merr <= ((bw ? m1_addr[1:0] : m0_addr[1:0]) != 2'b00) && !(bw ? (m1_we && m1_byte) : (m0_we && m0_byte));
      ph <= 1;
    end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk)
    if (run) begin
      chk("m0_ack", m0_ack, ph == 2 && !mw);
      chk("m1_ack", m1_ack, ph == 2 && mw);
      chk("m0_err", m0_err, ph == 2 && !mw && merr);
      chk("m1_err", m1_err, ph == 2 && mw && merr);
      chk("m0_rdata", m0_rdata, mrd[0]);
      chk("m1_rdata", m1_rdata, mrd[1]);
      chk("dm_we", dm_we, ph == 1 && mwe && !merr);
      chk("dm_op", dm_op, ph == 1 && mwe && mbt);
      if (ph == 1) begin
        chk("dm_addr", dm_addr, ma);
        chk("dm_din", dm_din, md);
      end
    end

  task automatic drive(input bit p, input bit r, input bit we, input bit bt, input logic [31:0] a, input logic [31:0] d);
    if (p) begin m1_req = r; m1_we = we; m1_byte = bt; m1_addr = a; m1_wdata = d; end
    else begin m0_req = r; m0_we = we; m0_byte = bt; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic txn(input bit p, input bit we, input bit bt, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output bit er, output int lat);
    @(negedge clk);
    drive(p, 1, we, bt, a, d);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!(p ? m1_ack : m0_ack) && lat < 20);
    chk("ack_seen", p ? m1_ack : m0_ack, 1);
    rd = p ? m1_rdata : m0_rdata;
    er = p ? m1_err : m0_err;
    drive(p, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] rd;
    bit er;
    int lat, n, c, s;
    int ord [6], at [6];
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    bit er;
    int lat, n, c, s;
    int ord [6], at [6];
    repeat (3) @(negedge clk);
    rst = 0;
    run = 1;
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    // 1: word store then load on M0
    txn(0, 1, 0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("t1_st_lat", lat, 2);
    chk("t1_st_err", er, 0);
    txn(0, 0, 0, 32'h10, 0, rd, er, lat);
    chk("t1_ld_lat", lat, 2);
    chk("t1_ld_data", rd, 32'hDEADBEEF);
    chk("t1_ld_err", er, 0);
    // 2: byte store into the top lane of a word on M1
    txn(1, 1, 0, 32'h10, 32'h11223344, rd, er, lat);
    txn(1, 1, 1, 32'h13, 32'h000000AA, rd, er, lat);
    chk("t2_bst_err", er, 0);
    txn(1, 0, 0, 32'h10, 0, rd, er, lat);
    chk("t2_ld_data", rd, 32'hAA223344);
    // 3: both held for six transactions -> strict alternation starting with M0
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h10, 0);
    drive(1, 1, 0, 0, 32'h4, 0);
    n = 0; c = 0;
    for (int i = 0; i < 6; i++) begin ord[i] = 9; at[i] = 0; end
    while (n < 6 && c < 60) begin
      @(negedge clk);
      c++;
      chk("t3_overlap", m0_ack & m1_ack, 0);
      if (m0_ack || m1_ack) begin ord[n] = m1_ack ? 1 : 0; at[n] = c; n++; end
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("t3_count", n, 6);
    for (int i = 0; i < 6; i++) chk("t3_order", ord[i], i % 2);
    for (int i = 1; i < 6; i++) chk("t3_spacing", at[i] - at[i-1], 3);
    // 4: misaligned word store and load are rejected
    txn(0, 1, 0, 32'h6, 32'h12345678, rd, er, lat);
    chk("t4_st_err", er, 1);
    chk("t4_mem_unchanged", mem[1], 0);
    txn(0, 0, 0, 32'h6, 0, rd, er, lat);
    chk("t4_ld_err", er, 1);
    chk("t4_ld_data", rd, 0);
    // 5: reset during the ACCESS cycle of an M1 store loses the write
    @(negedge clk);
    drive(1, 1, 1, 0, 32'h20, 32'h5);
    @(posedge clk);
    #2 rst = 1;
    #2 rst = 0;
    drive(1, 0, 0, 0, 0, 0);
    s = 0;
    repeat (5) begin @(negedge clk); s += int'(m1_ack); end
    chk("t5_no_ack", s, 0);
    chk("t5_mem_20", mem[8], 0);
    drive(0, 1, 0, 0, 32'h10, 0);
    drive(1, 1, 0, 0, 32'h20, 0);
    c = 0;
    do begin @(negedge clk); c++; end while (!(m0_ack || m1_ack) && c < 20);
    chk("t5_first_m0", {m0_ack, m1_ack}, 2'b10);
    drive(0, 0, 0, 0, 0, 0);
    c = 0;
    do begin @(negedge clk); c++; end while (!m1_ack && c < 20);
    chk("t5_m1_ack", m1_ack, 1);
    chk("t5_m1_data", m1_rdata, 0);
    drive(1, 0, 0, 0, 0, 0);
    // 6: M0 drops req after the grant edge; M1 is served next
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h10, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 32'h10, 0);
    c = 1;
    while (!m0_ack && c < 20) begin @(negedge clk); c++; end
    chk("t6_m0_lat", c, 2);
    chk("t6_m0_data", m0_rdata, 32'hAA223344);
    c = 0;
    do begin @(negedge clk); c++; end while (!m1_ack && c < 20);
    chk("t6_m1_gap", c, 3);
    drive(1, 0, 0, 0, 0, 0);
    // 7: upper address bits ignored
    txn(1, 0, 0, 32'h0000_1010, 0, rd, er, lat);
    chk("t7_wrap_data", rd, 32'hAA223344);
    chk("t7_wrap_err", er, 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
